imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-image loader and the core's instruction
// memory: the default memory geometry and the loader state enumeration.
// Both sides import this package so the memory depth and address width
// always agree.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    // Default instruction-memory geometry: 256 words of 32 bits.
    // IMEM_DEPTH must always equal 2**IMEM_ADDR_W.
    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = 8;

    // LOAD  : collecting bytes of the current word from the stream
    // WRITE : single-cycle write of the assembled word into memory
    // RUN   : image complete, core released from reset
    // ERROR : image overflowed the memory, core held in reset
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a boot image as a little-endian byte stream, packs it into 32-bit
// words, writes each word into instruction memory, and releases the
// downstream RISC-V core from reset once the final byte has been written.
// An image longer than DEPTH words stops the load in an error state with the
// core still held in reset. A reload pulse in RUN or ERROR restarts loading.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid       : byte-stream source has a byte
//   in_data[7:0]   : image byte (little-endian within each word)
//   in_last        : in_data is the final byte of the image
//   in_ready       : loader accepts a byte this cycle (LOAD only)
//   reload         : single-cycle restart request (honoured in RUN/ERROR)
//   imem_we        : instruction-memory write strobe
//   imem_addr      : word address of the write
//   imem_wdata     : assembled 32-bit word
//   core_rst       : reset to the core, low only once the image is loaded
//   done           : image loaded, core released
//   err            : image exceeded DEPTH words
//   words_loaded   : number of words written during this load
//
// DEPTH must equal 2**ADDR_W.
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t     state;
    loader_state_t     state_next;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              word_last;
    logic [ADDR_W:0]   count;
    logic              accept;

    assign accept       = in_valid && in_ready;
    assign imem_addr    = addr;
    assign imem_wdata   = word;
    assign words_loaded = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // A word is closed either when its fourth byte arrives or when the image
    // ends early; a partially filled word keeps zeros in its upper bytes
    // because the assembly register is cleared after every write.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        core_rst   = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (byte_cnt == 2'd3 || in_last)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                // A final word landing in the last slot is a clean finish,
                // so the in_last test has priority over the overflow test.
                if (word_last) begin
                    state_next = RUN;
                end else if (addr == LAST_ADDR) begin
                    state_next = ERROR;
                end else begin
                    state_next = LOAD;
                end
            end
            RUN: begin
                core_rst = 1'b0;
                done     = 1'b1;
                if (reload) begin
                    state_next = LOAD;
                end
            end
            ERROR: begin
                err = 1'b1;
                if (reload) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Datapath: byte assembly, word address and word count. The address
    // counter wraps to zero after the last slot, which is harmless because
    // the state machine leaves LOAD at that point; the count is one bit
    // wider so it can report a full memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= 2'd0;
            addr      <= '0;
            word      <= 32'd0;
            word_last <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        word[{byte_cnt, 3'b000} +: 8] <= in_data;
                        byte_cnt                      <= byte_cnt + 2'd1;
                        word_last                     <= in_last;
                    end
                end
                WRITE: begin
                    addr      <= addr + 1'b1;
                    count     <= count + 1'b1;
                    byte_cnt  <= 2'd0;
                    word      <= 32'd0;
                    word_last <= 1'b0;
                end
                RUN, ERROR: begin
                    if (reload) begin
                        addr      <= '0;
                        count     <= '0;
                        byte_cnt  <= 2'd0;
                        word      <= 32'd0;
                        word_last <= 1'b0;
                    end
                end
                default: begin
                    byte_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Drives byte images into a small (DEPTH=4) imem_loader and compares every
// memory write and the final status against a byte-stream reference model
// that chops the image into little-endian words and applies the overflow
// rule. Directed images come first, followed by randomized images.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int n_cmp  = 0;
    int n_fail = 0;

    // Current image and what the model expects from it
    logic [7:0]  img_data[$];
    bit          img_last[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_accepted;
    int          exp_end;
    int          exp_words;

    // Writes seen on the memory port
    int          got_addr[$];
    logic [31:0] got_data[$];

    // Byte index before which reload is pulsed while loading, and byte index
    // after whose acceptance reload is pulsed during the WRITE cycle
    int reload_at   = -1;
    int reload_w_at = -1;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst     (core_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Record every write; the loader must never offer a byte while writing
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            got_addr.push_back(int'(imem_addr));
            got_data.push_back(imem_wdata);
            checkOutput("ready_low_during_write", in_ready, 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: little-endian packing of the byte stream into words,
    // a word closing on its fourth byte or on the last byte; the load ends
    // with success on the last byte or with overflow after DEPTH words.
    task automatic model_image();
        logic [31:0] w;
        int          k;
        int          a;
        exp_addr.delete();
        exp_data.delete();
        exp_accepted = 0;
        exp_end      = 0;
        w = 32'd0;
        k = 0;
        a = 0;
        for (int i = 0; i < img_data.size() && exp_end == 0; i++) begin
            w = w | (32'(img_data[i]) << (8 * k));
            k++;
            exp_accepted++;
            if (k == 4 || img_last[i]) begin
                exp_addr.push_back(a);
                exp_data.push_back(w);
                a++;
                if (img_last[i]) exp_end = 1;
                else if (a == DEPTH) exp_end = 2;
                w = 32'd0;
                k = 0;
            end
        end
        exp_words = a;
    endtask

    // Offer one byte and hold it until accepted or the cycle budget expires.
    // Called and returns at 1 ns after a rising edge.
    task automatic send_byte(input logic [7:0] d, input bit l, input int budget,
                             output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom_range(255));
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_in_ready"},     in_ready, 1);
        checkOutput({tag, "_imem_we"},      imem_we, 0);
        checkOutput({tag, "_imem_addr"},    imem_addr, 0);
        checkOutput({tag, "_imem_wdata"},   imem_wdata, 0);
        checkOutput({tag, "_core_rst"},     core_rst, 1);
        checkOutput({tag, "_done"},         done, 0);
        checkOutput({tag, "_err"},          err, 0);
        checkOutput({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    task automatic check_first_write(input string tag, input int a, input logic [31:0] d);
        checkOutput({tag, "_has_write"}, got_addr.size() > 0, 1);
        if (got_addr.size() > 0) begin
            checkOutput({tag, "_addr"}, got_addr[0], a);
            checkOutput({tag, "_data"}, got_data[0], d);
        end
    endtask

    // Send the current image with random idle gaps, check completion latency,
    // then compare all writes and the final status against the model
    task automatic applyStimulus(input int gap_min, input int gap_max);
        bit ok;
        int g;
        model_image();
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < exp_accepted; i++) begin
            g = int'($urandom_range(gap_max, gap_min));
            idle(g);
            if (i == reload_at) pulse_reload();
            send_byte(img_data[i], img_last[i], 50, ok);
            checkOutput("byte_accepted", ok, 1);
            if (i == reload_w_at) pulse_reload();
        end
        if (exp_end != 0) begin
            @(negedge clk);
            checkOutput("we_after_final_byte", imem_we, 1);
            checkOutput("core_rst_in_write", core_rst, 1);
            @(posedge clk);
            #1;
            checkOutput("done_latency", done, exp_end == 1);
            checkOutput("err_latency", err, exp_end == 2);
            checkOutput("core_rst_latency", core_rst, exp_end == 2);
            if (exp_end == 2 && img_data.size() > exp_accepted) begin
                send_byte(img_data[exp_accepted], img_last[exp_accepted], 5, ok);
                checkOutput("byte_rejected_in_error", ok, 0);
            end
        end
        idle(2);
        checkOutput("write_count", got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < got_addr.size()) begin
                checkOutput($sformatf("write%0d_addr", i), got_addr[i], exp_addr[i]);
                checkOutput($sformatf("write%0d_data", i), got_data[i], exp_data[i]);
            end
        end
        checkOutput("words_loaded", words_loaded, exp_words);
        checkOutput("imem_we_idle", imem_we, 0);
        checkOutput("final_done", done, exp_end == 1);
        checkOutput("final_err", err, exp_end == 2);
        checkOutput("final_core_rst", core_rst, exp_end != 1);
        checkOutput("final_in_ready", in_ready, exp_end == 0);
    endtask

    initial begin
        bit ok;
        int len;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        reload   = 1'b0;

        // Reset state, during and after reset
        idle(3);
        check_reset_outputs("reset_held");
        rst = 1'b0;
        idle(1);
        check_reset_outputs("reset_released");

        // Single full word, last on the fourth byte
        $display("[TB] step: single word image");
        img_data = '{8'h13, 8'h05, 8'h50, 8'h00};
        img_last = '{0, 0, 0, 1};
        applyStimulus(0, 0);
        check_first_write("single_word", 0, 32'h00500513);

        // Reload from RUN, then a fresh one-word image
        $display("[TB] step: reload from RUN");
        pulse_reload();
        checkOutput("reload_core_rst", core_rst, 1);
        checkOutput("reload_done", done, 0);
        checkOutput("reload_words", words_loaded, 0);
        checkOutput("reload_addr", imem_addr, 0);
        checkOutput("reload_in_ready", in_ready, 1);
        img_data = '{8'h6F, 8'h00, 8'h00, 8'h00};
        img_last = '{0, 0, 0, 1};
        applyStimulus(0, 0);
        check_first_write("after_reload", 0, 32'h0000006F);

        // Eight bytes with three idle cycles between them
        $display("[TB] step: two words with gaps");
        pulse_reload();
        img_data.delete();
        img_last.delete();
        for (int i = 0; i < 8; i++) begin
            img_data.push_back(8'($urandom_range(255)));
            img_last.push_back(i == 7);
        end
        applyStimulus(3, 3);

        // Short final word is zero-padded
        $display("[TB] step: partial final word");
        pulse_reload();
        img_data = '{8'hAA, 8'hBB, 8'hCC};
        img_last = '{0, 0, 1};
        applyStimulus(0, 1);
        check_first_write("partial_word", 0, 32'h00CCBBAA);

        // Seventeen bytes without last overflow a four-word memory
        $display("[TB] step: overflow");
        pulse_reload();
        img_data.delete();
        img_last.delete();
        for (int i = 0; i < 17; i++) begin
            img_data.push_back(8'($urandom_range(255)));
            img_last.push_back(1'b0);
        end
        applyStimulus(0, 1);

        // Exactly DEPTH words ending on last; reload while loading and while
        // writing must both be ignored
        $display("[TB] step: full memory with ignored reloads");
        pulse_reload();
        checkOutput("reload_clears_err", err, 0);
        img_data.delete();
        img_last.delete();
        for (int i = 0; i < 16; i++) begin
            img_data.push_back(8'($urandom_range(255)));
            img_last.push_back(i == 15);
        end
        reload_at   = 5;
        reload_w_at = 7;
        applyStimulus(0, 1);
        reload_at   = -1;
        reload_w_at = -1;

        // Asynchronous reset while running re-asserts the core reset at once
        $display("[TB] step: reset in RUN");
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_in_run");
        #1;
        rst = 1'b0;
        idle(1);

        // Reset after two bytes discards the partial word
        $display("[TB] step: reset mid-word");
        got_addr.delete();
        got_data.delete();
        send_byte(8'hDE, 1'b0, 10, ok);
        send_byte(8'hAD, 1'b0, 10, ok);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_word");
        #1;
        rst = 1'b0;
        idle(3);
        checkOutput("no_write_after_rst", got_addr.size(), 0);
        img_data = '{8'h01, 8'h02, 8'h03, 8'h04};
        img_last = '{0, 0, 0, 1};
        applyStimulus(0, 1);
        check_first_write("after_rst", 0, 32'h04030201);

        // Randomized images: mostly terminated, some overflowing
        $display("[TB] step: random images");
        for (int t = 0; t < 20; t++) begin
            pulse_reload();
            img_data.delete();
            img_last.delete();
            if ($urandom_range(3) == 0) begin
                len = int'($urandom_range(20, 17));
                for (int i = 0; i < len; i++) begin
                    img_data.push_back(8'($urandom_range(255)));
                    img_last.push_back(1'b0);
                end
            end else begin
                len = int'($urandom_range(16, 1));
                for (int i = 0; i < len; i++) begin
                    img_data.push_back(8'($urandom_range(255)));
                    img_last.push_back(i == len - 1);
                end
            end
            applyStimulus(0, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
